// File: rtl/noc_tx_serializer.sv
// Transmit-side NOCI byte link: buffers 64-bit core results in a small FIFO and
// frames them into header/length/payload byte packets, LSB byte first.
module noc_tx_serializer #(
   parameter int unsigned PKT_WORDS  = 25,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [2:0]  HDR_CODE   = 3'b011,
   parameter logic [4:0]  DEST_ID    = 5'd0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pushout,
   input  logic        firstout,
   input  logic [63:0] dout,
   output logic        stopout,
   output logic        noc_from_dev_ctl,
   output logic [7:0]  noc_from_dev_data,
   output logic        err_overflow,
   output logic        err_framing
);
   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned IW = $clog2(PKT_WORDS + 1);

   localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] STOP_LVL = CW'(FIFO_DEPTH - 1);
   localparam logic [CW-1:0] ONE_C    = CW'(1);
   localparam logic [PW-1:0] PTR_MAX  = PW'(FIFO_DEPTH - 1);
   localparam logic [IW-1:0] IDX_MAX  = IW'(PKT_WORDS - 1);
   localparam logic [7:0]    HDR_BYTE = {HDR_CODE, DEST_ID};
   localparam logic [7:0]    LEN_BYTE = 8'(8 * PKT_WORDS);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_HDR   = 3'd1;
   localparam logic [2:0] S_LEN   = 3'd2;
   localparam logic [2:0] S_DATA  = 3'd3;
   localparam logic [2:0] S_STALL = 3'd4;

   logic [63:0]   mem_q [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_next;
   logic [CW-1:0] count_q, count_d;
   logic [IW-1:0] in_idx_q, in_idx_d, out_word_q, out_word_d;
   logic [2:0]    state_q, state_d, byte_idx_q, byte_idx_d;
   logic          ctl_q, ctl_d, ovf_q, ovf_d, frm_q, frm_d;
   logic [7:0]    data_q, data_d, head0_next;
   logic          full, push_acc, pop;

   assign full     = (count_q == DEPTH_C);
   assign push_acc = pushout && !full;
   assign pop      = (state_q == S_DATA) && (byte_idx_q == 3'd7);
   assign stopout  = (count_q >= STOP_LVL);

   assign noc_from_dev_ctl  = ctl_q;
   assign noc_from_dev_data = data_q;
   assign err_overflow      = ovf_q;
   assign err_framing       = frm_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      if (push_acc) wr_ptr_d = (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + PW'(1);
      rd_next  = (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + PW'(1);
      rd_ptr_d = pop ? rd_next : rd_ptr_q;
      count_d  = count_q;
      if (push_acc && !pop)      count_d = count_q + ONE_C;
      else if (!push_acc && pop) count_d = count_q - ONE_C;
   end

   // Word following a pop: next stored entry, or the word being pushed this
   // same cycle when the popped entry was the only one buffered.
   assign head0_next = (count_q > ONE_C) ? mem_q[rd_next][7:0] : dout[7:0];

   always_comb begin
      in_idx_d = in_idx_q;
      frm_d    = frm_q;
      ovf_d    = ovf_q | (pushout & full);
      if (push_acc) begin
         in_idx_d = (in_idx_q == IDX_MAX) ? '0 : in_idx_q + IW'(1);
         frm_d    = frm_q | (firstout != (in_idx_q == '0));
      end
   end

   always_comb begin
      state_d    = state_q;
      byte_idx_d = byte_idx_q;
      out_word_d = out_word_q;
      ctl_d      = 1'b1;
      data_d     = '0;
      case (state_q)
         S_IDLE: begin
            if (count_q != '0) begin
               state_d = S_HDR;
               data_d  = HDR_BYTE;
            end
         end
         S_HDR: begin
            state_d = S_LEN;
            ctl_d   = 1'b0;
            data_d  = LEN_BYTE;
         end
         S_LEN: begin
            state_d    = S_DATA;
            byte_idx_d = '0;
            out_word_d = '0;
            ctl_d      = 1'b0;
            data_d     = mem_q[rd_ptr_q][7:0];
         end
         S_DATA: begin
            if (byte_idx_q != 3'd7) begin
               byte_idx_d = byte_idx_q + 3'd1;
               ctl_d      = 1'b0;
               data_d     = mem_q[rd_ptr_q][{byte_idx_d, 3'b000} +: 8];
            end else begin
               byte_idx_d = '0;
               if (out_word_q == IDX_MAX) begin
                  out_word_d = '0;
                  if (count_d != '0) begin
                     state_d = S_HDR;
                     data_d  = HDR_BYTE;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  out_word_d = out_word_q + IW'(1);
                  if (count_d != '0) begin
                     ctl_d  = 1'b0;
                     data_d = head0_next;
                  end else begin
                     state_d = S_STALL;
                  end
               end
            end
         end
         S_STALL: begin
            if (count_q != '0) begin
               state_d = S_DATA;
               ctl_d   = 1'b0;
               data_d  = mem_q[rd_ptr_q][7:0];
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         in_idx_q   <= '0;
         out_word_q <= '0;
         byte_idx_q <= '0;
         state_q    <= S_IDLE;
         ctl_q      <= 1'b1;
         data_q     <= '0;
         ovf_q      <= 1'b0;
         frm_q      <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         in_idx_q   <= in_idx_d;
         out_word_q <= out_word_d;
         byte_idx_q <= byte_idx_d;
         state_q    <= state_d;
         ctl_q      <= ctl_d;
         data_q     <= data_d;
         ovf_q      <= ovf_d;
         frm_q      <= frm_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_acc) mem_q[wr_ptr_q] <= dout;
   end
endmodule

// File: tb/tb_noc_tx_serializer.sv
// Bench for noc_tx_serializer: each accepted word is scheduled onto an expected
// per-cycle byte timeline; every cycle's outputs are compared to that timeline.
module tb_noc_tx_serializer;
   localparam int unsigned P   = 2;
   localparam int unsigned D   = 4;
   localparam logic [2:0]  HC  = 3'b011;
   localparam logic [4:0]  DID = 5'd3;

   logic        clk = 1'b0;
   logic        reset, pushout, firstout;
   logic [63:0] dout;
   logic        stopout, noc_from_dev_ctl, err_overflow, err_framing;
   logic [7:0]  noc_from_dev_data;

   noc_tx_serializer #(.PKT_WORDS(P), .FIFO_DEPTH(D), .HDR_CODE(HC), .DEST_ID(DID)) dut (
      .clk(clk), .reset(reset), .pushout(pushout), .firstout(firstout), .dout(dout),
      .stopout(stopout), .noc_from_dev_ctl(noc_from_dev_ctl),
      .noc_from_dev_data(noc_from_dev_data), .err_overflow(err_overflow),
      .err_framing(err_framing));

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_mis = 0;
   int cyc   = 0;
   logic [8:0] exp_out [int];
   int push_t[$];
   int pop_t[$];
   int m_acc  = 0;
   int m_last = -1000;
   bit m_ovf  = 1'b0;
   bit m_frm  = 1'b0;

   function automatic int model_count(input int e);
      int c = 0;
      foreach (push_t[i]) if (push_t[i] <= e) c++;
      foreach (pop_t[i])  if (pop_t[i]  <= e) c--;
      return c;
   endfunction

   task automatic model_reset();
      exp_out.delete();
      push_t.delete();
      pop_t.delete();
      m_acc = 0; m_last = -1000; m_ovf = 1'b0; m_frm = 1'b0;
   endtask

   // A word's bytes start the cycle after the previous word finishes, or the
   // cycle after its own push if it arrives later than that.
   task automatic model_accept(input int t, input logic f, input logic [63:0] d);
      int base;
      bit is_first;
      is_first = ((m_acc % P) == 0);
      if (f != is_first) m_frm = 1'b1;
      base = (t <= m_last + 1) ? m_last + 1 : t + 1;
      if (is_first) begin
         exp_out[base]     = {1'b1, HC, DID};
         exp_out[base + 1] = {1'b0, 8'(8 * P)};
         base += 2;
      end
      for (int j = 0; j < 8; j++) exp_out[base + j] = {1'b0, d[8*j +: 8]};
      m_last = base + 7;
      push_t.push_back(t);
      pop_t.push_back(m_last + 1);
      m_acc++;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_mis++;
         $error("FAIL %s cyc=%0d: observed %h expected %h", tag, cyc, obs, expv);
      end
   endtask

   task automatic check_outputs();
      logic [8:0] e;
      e = exp_out.exists(cyc) ? exp_out[cyc] : 9'h100;
      chk("byte", {noc_from_dev_ctl, noc_from_dev_data}, e);
      chk("stopout", stopout, (model_count(cyc) >= int'(D) - 1));
      chk("err_overflow", err_overflow, m_ovf);
      chk("err_framing", err_framing, m_frm);
   endtask

   task automatic tick(input logic p, input logic f, input logic [63:0] d, input logic r);
      pushout = p; firstout = f; dout = d; reset = r;
      @(posedge clk);
      cyc++;
      if (r) model_reset();
      else if (p) begin
         if (model_count(cyc - 1) >= int'(D)) m_ovf = 1'b1;
         else model_accept(cyc, f, d);
      end
      #1;
      check_outputs();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 64'h0, 1'b0);
   endtask

   task automatic push_word(input logic [63:0] d);
      tick(1'b1, ((m_acc % P) == 0), d, 1'b0);
   endtask

   task automatic push_rand();
      push_word({$urandom(), $urandom()});
   endtask

   initial begin
      int pushed;
      reset = 1'b1; pushout = 1'b0; firstout = 1'b0; dout = '0;
      tick(1'b0, 1'b0, 64'h0, 1'b1);
      tick(1'b0, 1'b0, 64'h0, 1'b1);
      idle(2);

      // Two-word packet, consecutive pushes.
      push_word(64'h0807060504030201);
      push_word(64'h100F0E0D0C0B0A09);
      idle(25);

      // Six words honouring stopout: three back-to-back packets.
      pushed = 0;
      for (int i = 0; i < 100 && pushed < 6; i++) begin
         if (!stopout) begin
            push_rand();
            pushed++;
         end else idle(1);
      end
      chk("t2_push_budget", pushed, 6);
      idle(70);

      // Second word arrives late: payload stalls with idle bytes.
      push_rand();
      idle(19);
      push_rand();
      idle(15);

      // Random traffic honouring stopout.
      for (int i = 0; i < 200; i++) begin
         if (!stopout && ($urandom_range(0, 2) != 0)) push_rand();
         else idle(1);
      end
      idle(80);

      // Framing error: word at position 0 without firstout.
      tick(1'b1, ((m_acc % P) != 0), {$urandom(), $urandom()}, 1'b0);
      push_rand();
      idle(30);

      // Overflow: five back-to-back pushes ignoring stopout.
      for (int i = 0; i < 5; i++) push_rand();
      idle(50);

      // Reset in the middle of payload, then a clean packet.
      push_rand();
      idle(6);
      tick(1'b0, 1'b0, 64'h0, 1'b1);
      idle(2);
      push_rand();
      push_rand();
      idle(30);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
